// File: rtl/i2s_rx_core.sv
// I2S receiver: recovers left/right words from a ws/sd stream clocked by sck and queues
// complete stereo frames in a small show-ahead FIFO with a sticky overrun flag.
module i2s_rx_core #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          sck,
  input  logic          reset_n,
  input  logic          ws,
  input  logic          sd,
  input  logic          rd_en,
  input  logic          clr_ovr,
  output logic [DW-1:0] data_left,
  output logic [DW-1:0] data_right,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun
);

  localparam int unsigned CW       = $clog2(DW + 1);
  localparam logic [CW-1:0] DwLen   = CW'(DW);
  localparam logic [CW-1:0] LastBit = CW'(DW - 1);
  localparam logic [AW:0]   DepthC  = (AW + 1)'(DEPTH);

  logic          ws_d1, ws_d2, ws_p;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] left_hold;
  logic          chan;
  logic          active;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic          word_done;
  logic [DW-1:0] word;
  logic          push, pop, push_ok, drop;

  assign ws_p = ws_d1 ^ ws_d2;

  // A channel change while a word is open either truncates it (left-aligned) or,
  // with no bits yet received, silently abandons it.
  always_comb begin
    word_done = 1'b0;
    word      = '0;
    if (active) begin
      if (ws_p) begin
        word_done = (bit_cnt != '0);
        word      = shreg << (DwLen - bit_cnt);
      end else if (bit_cnt == LastBit) begin
        word_done = 1'b1;
        word      = {shreg[DW-2:0], sd};
      end
    end
  end

  assign push    = word_done & chan;
  assign pop     = rd_en & ~empty;
  assign push_ok = push & (~full | rd_en);
  assign drop    = push & full & ~rd_en;

  always_ff @(posedge sck) begin
    if (!reset_n) begin
      ws_d1     <= 1'b0;
      ws_d2     <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      left_hold <= '0;
      chan      <= 1'b0;
      active    <= 1'b0;
    end else begin
      ws_d1 <= ws;
      ws_d2 <= ws_d1;
      if (ws_p) begin
        bit_cnt <= '0;
        shreg   <= '0;
        chan    <= ws_d1;
        active  <= 1'b1;
      end else if (active && bit_cnt < DwLen) begin
        shreg   <= {shreg[DW-2:0], sd};
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt == LastBit) begin
          active <= 1'b0;
        end
      end
      if (word_done) begin
        left_hold <= chan ? '0 : word;
      end
    end
  end

  always_ff @(posedge sck) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (!push_ok && pop) begin
        count <= count - (AW + 1)'(1);
      end
      // A drop on the same edge as a clear wins so no overrun is ever lost.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge sck) begin
    if (reset_n && push_ok) begin
      mem[wr_ptr] <= {left_hold, word};
    end
  end

  assign empty      = (count == '0);
  assign full       = (count == DepthC);
  assign data_left  = mem[rd_ptr][2*DW-1:DW];
  assign data_right = mem[rd_ptr][DW-1:0];

endmodule

// File: tb/tb_i2s_rx_core.sv
// Directed and randomized bench for i2s_rx_core (DW=16, DEPTH=4) against a frame-queue model.
module tb_i2s_rx_core;

  logic        sck = 1'b0;
  logic        reset_n, ws, sd, rd_en, clr_ovr;
  logic [15:0] data_left, data_right;
  logic        empty, full, overrun;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  logic        ovr_m = 1'b0;

  i2s_rx_core #(.DW(16), .DEPTH(4)) dut (
    .sck       (sck),
    .reset_n   (reset_n),
    .ws        (ws),
    .sd        (sd),
    .rd_en     (rd_en),
    .clr_ovr   (clr_ovr),
    .data_left (data_left),
    .data_right(data_right),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == 4));
    check({tag, ".overrun"}, 32'(overrun), 32'(ovr_m));
    if (q.size() != 0) begin
      check({tag, ".left"}, 32'(data_left), 32'(q[0][31:16]));
      check({tag, ".right"}, 32'(data_right), 32'(q[0][15:0]));
    end
  endtask

  // Frame capacity rule: a frame arriving at a full FIFO (no read) is lost and flagged.
  task automatic model_push(input logic [31:0] f);
    if (q.size() < 4) q.push_back(f);
    else ovr_m = 1'b1;
  endtask

  // Transmitter: ws changes, one idle bit slot, then n bits MSB first.
  task automatic send_word(input logic ch, input logic [31:0] val, input int n);
    @(negedge sck);
    ws = ch;
    sd = 1'b0;
    @(negedge sck);
    sd = 1'b0;
    for (int k = n - 1; k >= 0; k--) begin
      @(negedge sck);
      sd = val[k];
    end
  endtask

  // Brief right-channel pulse so that a following left word sees a channel change.
  task automatic sync_left();
    @(negedge sck);
    ws = 1'b1;
    sd = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, 32'(l), 16);
    send_word(1'b1, 32'(r), 16);
    @(negedge sck);
    model_push({l, r});
  endtask

  task automatic pop_check(input string tag);
    check({tag, ".left"}, 32'(data_left), 32'(q[0][31:16]));
    check({tag, ".right"}, 32'(data_right), 32'(q[0][15:0]));
    rd_en = 1'b1;
    @(negedge sck);
    rd_en = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    logic [15:0] l1, l2, l3, r8;
    logic [31:0] pending;
    reset_n = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    rd_en   = 1'b0;
    clr_ovr = 1'b0;
    repeat (3) @(negedge sck);
    check_state("reset");
    reset_n = 1'b1;

    // Basic frame
    sync_left();
    send_frame(16'hA5C3, 16'h1234);
    check_state("basic");
    pop_check("basic_pop");
    check_state("basic_empty");

    // Short right words (completed by next ws change) and a long right word
    l1 = 16'($urandom);
    l2 = 16'($urandom);
    l3 = 16'($urandom);
    r8 = 16'($urandom_range(1, 255));
    send_word(1'b0, 32'(l1), 16);
    send_word(1'b1, 32'h00, 8);
    send_word(1'b0, 32'(l2), 16);
    model_push({l1, 16'h0000});
    send_word(1'b1, 32'(r8), 8);
    send_word(1'b0, 32'(l3), 16);
    model_push({l2, r8[7:0], 8'h00});
    send_word(1'b1, 32'hFFFFF, 20);
    @(negedge sck);
    model_push({l3, 16'hFFFF});
    check_state("shortlong");
    while (q.size() != 0) pop_check("shortlong_pop");
    check_state("shortlong_empty");

    // Overflow: five frames, no reads
    for (int i = 0; i < 5; i++) send_frame(16'($urandom), 16'($urandom));
    check_state("overflow");
    clr_ovr = 1'b1;
    @(negedge sck);
    clr_ovr = 1'b0;
    ovr_m   = 1'b0;
    check_state("clr_ovr");

    // Push coincident with a read while full
    l1 = 16'($urandom);
    r8 = 16'($urandom);
    send_word(1'b0, 32'(l1), 16);
    send_word(1'b1, 32'(r8), 16);
    rd_en = 1'b1;
    @(negedge sck);
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back({l1, r8});
    check_state("push_pop_full");

    // Drop together with clr_ovr: overrun must stay set
    send_word(1'b0, 32'($urandom), 16);
    send_word(1'b1, 32'($urandom), 16);
    clr_ovr = 1'b1;
    @(negedge sck);
    clr_ovr = 1'b0;
    ovr_m   = 1'b1;
    check_state("drop_vs_clr");

    // Reset at bit 7 of a left word while left-hold holds a completed word
    pending = 32'($urandom);
    send_word(1'b0, 32'($urandom), 16);
    sync_left();
    send_word(1'b0, pending >> 9, 7);
    @(negedge sck);
    reset_n = 1'b0;
    @(negedge sck);
    q.delete();
    ovr_m = 1'b0;
    check_state("midword_reset");
    reset_n = 1'b1;
    r8 = 16'($urandom);
    send_word(1'b1, 32'(r8), 16);
    @(negedge sck);
    model_push({16'h0000, r8});
    check_state("after_reset");
    pop_check("after_reset_pop");

    // Loopback of random frames, read back in order
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) send_frame(16'($urandom), 16'($urandom));
      check_state("loop_fill");
      while (q.size() != 0) pop_check("loop_pop");
    end
    check_state("loop_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx_core.md
I2S_RX_CORE -- requirements
Module: i2s_rx_core

Interface
REQ-001 Parameter DW, default 16, audio word width in bits per channel (>=2).
REQ-002 Parameter DEPTH, default 4, stereo-frame FIFO depth (power of two, >=2); AW = log2(DEPTH).
REQ-003 sck  input  1  bit clock; sole clock, all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 ws  input  1  word select; 0 = left channel, 1 = right channel.
REQ-006 sd  input  1  serial data, MSB first.
REQ-007 rd_en  input  1  pop head frame; ignored when empty.
REQ-008 clr_ovr  input  1  clears overrun flag.
REQ-009 data_left  output  DW  left word of FIFO head frame (show-ahead).
REQ-010 data_right  output  DW  right word of FIFO head frame (show-ahead).
REQ-011 empty  output  1  FIFO holds no frame.
REQ-012 full  output  1  FIFO holds DEPTH frames.
REQ-013 count  output  AW+1  frames held, 0..DEPTH.
REQ-014 overrun  output  1  sticky; a frame was dropped.

Function
REQ-015 ws SHALL pass through two registers ws_d1, ws_d2; ws_p = ws_d1 XOR ws_d2 marks a channel change.
REQ-016 On an edge with ws_p=1: bit counter cleared to 0, shift register cleared, current channel latched from ws_d1, word-active set.
REQ-017 Timing: ws change before edge E0 -> ws_p high at E1 -> MSB sampled from sd at E2, bit k (MSB = 0) sampled at E(2+k).
REQ-018 While word-active and counter < DW: each edge shifts sd into LSB, counter increments.
REQ-019 Word completes on the edge sampling the DW-th bit; word-active clears; further bits before next ws_p ignored (long word, extra LSBs discarded).
REQ-020 Short word: ws_p arriving with word-active set and counter >= 1 completes the partial word left-aligned, missing LSBs zero, on that same edge, and starts the new word.
REQ-021 ws_p with word-active set and counter = 0 discards the pending word (no completion).
REQ-022 Completed left word stored in left-hold register; no FIFO push.
REQ-023 Completed right word pushes {left-hold, right word} into FIFO; left-hold then cleared to 0 (right word without prior left -> left = 0).
REQ-024 Push when not full, or when full with rd_en in same cycle: accepted; count unchanged for simultaneous push+pop.
REQ-025 Push when full and rd_en=0: frame dropped, FIFO unchanged, overrun set next edge.
REQ-026 Pop with rd_en=1 and not empty: read pointer advances, count decrements; rd_en on empty: no effect.
REQ-027 Pointers wrap modulo DEPTH; empty = (count==0), full = (count==DEPTH), all registered or derived from count.
REQ-028 data_left/data_right SHALL reflect the head entry combinationally from the storage array; value undefined-free (holds stale entry) when empty.
REQ-029 overrun clears on clr_ovr=1; clr_ovr and a drop on same edge -> overrun stays 1.

Reset
REQ-030 reset_n=0 at an edge: ws_d1, ws_d2, counter, shift register, left-hold, word-active, pointers, count, overrun cleared; empty=1, full=0, count=0; storage contents need not reset.
REQ-031 Reset mid-word discards the partial word; first capture after release requires a fresh ws_p.

Verification
REQ-032 DW=16: send left 0xA5C3 (ws=0), right 0x1234 (ws=1), standard timing -> one push, count=1, data_left=0xA5C3, data_right=0x1234.
REQ-033 Right word 0x00FF with only 8 bits (0x00) before ws toggles -> data_right=0x0000 with 8 LSBs zero; 20 bits of 0xFFFFF -> data_right=0xFFFF, extra 4 bits dropped.
REQ-034 DEPTH=4: push 5 frames, no reads -> count=4, full=1, overrun=1, head = first frame; clr_ovr -> overrun=0.
REQ-035 Full FIFO, push coincident with rd_en=1 -> count stays 4, overrun=0, head advances to frame 2.
REQ-036 Assert reset_n=0 for one edge at bit 7 of a left word -> all outputs at reset values; next complete frame captured correctly with left per REQ-023.
REQ-037 Loopback: drive ws/sd from the team's existing I2S transmitter core with 8 random frames -> bit-exact frames read out in order.
